mem_stage_access: RTL and testbench

Memory-access stage that sits directly downstream of the EX/MEM control/data pipeline registers. It consumes mem_read/mem_write/branch plus the address, store data and access size. It then runs one request/response transaction on the data-memory bus per access and stalls the pipeline until the access completes. Load data is aligned and sign/zero-extended before it goes to the MEM/WB register.

---
 rtl/mem_stage_access.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_access.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_access
//  Description : Memory-access pipeline stage. Performs one request/response
//                transaction per load/store on the data-memory bus, stalls the
//                upstream pipeline while it is in flight, places store data on
//                the correct byte lanes and aligns/extends load data.
//  Options     : MEM_MISALIGN_TRAP_EN - trap misaligned accesses instead of
//                issuing them (adds misaligned_out / fault_addr_out).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_access #(
    parameter int XLEN   = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic [XLEN-1:0]   addr_in,
    input  logic [XLEN-1:0]   wdata_in,
    input  logic [2:0]        funct3_in,
    output logic              branch_taken_out,
    output logic              stall_out,
    output logic [XLEN-1:0]   load_data_out,
    output logic              access_done_out,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [XLEN-1:0]   dmem_req_addr,
    output logic [XLEN-1:0]   dmem_req_wdata,
    output logic [STRB_W-1:0] dmem_req_wstrb,
    input  logic              dmem_resp_valid,
    input  logic [XLEN-1:0]   dmem_resp_rdata
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misaligned_out,
    output logic [XLEN-1:0]   fault_addr_out
`endif
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Byte offset and size/sign of the access in flight, needed when the
    // read data returns.
    logic [2:0]        r_off;
    logic [2:0]        r_funct3;

    logic              w_access;
    logic [2:0]        w_off;
    logic [STRB_W-1:0] w_size_mask;
    logic [STRB_W-1:0] w_lane_strb;
    logic [XLEN-1:0]   w_lane_wdata;
    logic              w_trap;
    logic [XLEN-1:0]   w_load_shift;
    logic [XLEN-1:0]   w_load_ext;

    assign w_access = mem_read_in | mem_write_in;
    assign w_off    = addr_in[2:0];

    // Byte-enable pattern for the access size; funct3[1:0] encodes size for
    // both signed and unsigned loads, and 11 (D or the unused 111) is full.
    always_comb begin
        w_size_mask = STRB_W'(8'hFF);
        case (funct3_in[1:0])
            2'b00:   w_size_mask = STRB_W'(8'h01);
            2'b01:   w_size_mask = STRB_W'(8'h03);
            2'b10:   w_size_mask = STRB_W'(8'h0F);
            default: w_size_mask = STRB_W'(8'hFF);
        endcase
    end

    // Strobes are also driven for loads so the bus sees which bytes are used.
    // Bytes shifted past lane 7 fall off the top and are simply not written.
    assign w_lane_strb  = w_size_mask << w_off;
    assign w_lane_wdata = wdata_in << {w_off, 3'b000};

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misaligned;

    // An access is misaligned when its offset is not a multiple of its size.
    always_comb begin
        w_misaligned = 1'b0;
        case (funct3_in[1:0])
            2'b01:   w_misaligned = w_off[0];
            2'b10:   w_misaligned = |w_off[1:0];
            2'b11:   w_misaligned = |w_off;
            default: w_misaligned = 1'b0;
        endcase
    end

    assign w_trap = w_misaligned;
`else
    assign w_trap = 1'b0;
`endif

    // Bring the addressed byte down to bit 0, then truncate and extend.
    assign w_load_shift = dmem_resp_rdata >> {r_off, 3'b000};

    // Size truncation with sign (B/H/W) or zero (BU/HU/WU) extension.
    always_comb begin
        w_load_ext = w_load_shift;
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_load_shift[7]}},   w_load_shift[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_load_shift[15]}}, w_load_shift[15:0]};
            3'b010:  w_load_ext = {{(XLEN-32){w_load_shift[31]}}, w_load_shift[31:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  w_load_shift[7:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_load_shift[15:0]};
            3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, w_load_shift[31:0]};
            default: w_load_ext = w_load_shift;
        endcase
    end

    // Hold the pipeline from the cycle an access appears until the response
    // arrives; DONE releases it so the instruction advances exactly once.
    assign stall_out = ((r_state == c_S_IDLE) & w_access) |
                       (r_state == c_S_REQ) |
                       (r_state == c_S_WAIT);

    assign branch_taken_out = branch_in & ~stall_out;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic for the single outstanding bus transaction.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_access) begin
                    w_state_nxt = w_trap ? c_S_DONE : c_S_REQ;
                end
            end
            c_S_REQ: begin
                if (dmem_req_ready) begin
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (dmem_resp_valid) begin
                    w_state_nxt = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_state_nxt = c_S_IDLE;
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Request latching, bus handshake, load capture and completion pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_off           <= 3'b000;
            r_funct3        <= 3'b000;
            dmem_req_valid  <= 1'b0;
            dmem_req_we     <= 1'b0;
            dmem_req_addr   <= '0;
            dmem_req_wdata  <= '0;
            dmem_req_wstrb  <= '0;
            load_data_out   <= '0;
            access_done_out <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_out  <= 1'b0;
            fault_addr_out  <= '0;
`endif
        end else begin
            access_done_out <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misaligned_out  <= 1'b0;
`endif
            case (r_state)
                c_S_IDLE: begin
                    if (w_access) begin
                        r_off          <= w_off;
                        r_funct3       <= funct3_in;
                        dmem_req_we    <= mem_write_in;
                        dmem_req_addr  <= {addr_in[XLEN-1:3], 3'b000};
                        dmem_req_wdata <= w_lane_wdata;
                        dmem_req_wstrb <= w_lane_strb;
                        if (w_trap) begin
                            access_done_out <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                            misaligned_out  <= 1'b1;
                            fault_addr_out  <= addr_in;
`endif
                        end else begin
                            dmem_req_valid <= 1'b1;
                        end
                    end
                end
                c_S_REQ: begin
                    if (dmem_req_ready) begin
                        dmem_req_valid <= 1'b0;
                    end
                end
                c_S_WAIT: begin
                    if (dmem_resp_valid) begin
                        access_done_out <= 1'b1;
                        if (!dmem_req_we) begin
                            load_data_out <= w_load_ext;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_access
//  Description : Scoreboard bench for mem_stage_access. Stimulus pushes the
//                expected bus request and completion result; a negedge
//                monitor compares them when the DUT presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_access;

    localparam int XLEN   = 64;
    localparam int STRB_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              branch_in = 1'b0;
    logic              mem_read_in = 1'b0;
    logic              mem_write_in = 1'b0;
    logic [XLEN-1:0]   addr_in = '0;
    logic [XLEN-1:0]   wdata_in = '0;
    logic [2:0]        funct3_in = 3'b000;
    logic              branch_taken_out;
    logic              stall_out;
    logic [XLEN-1:0]   load_data_out;
    logic              access_done_out;
    logic              dmem_req_valid;
    logic              dmem_req_ready = 1'b0;
    logic              dmem_req_we;
    logic [XLEN-1:0]   dmem_req_addr;
    logic [XLEN-1:0]   dmem_req_wdata;
    logic [STRB_W-1:0] dmem_req_wstrb;
    logic              dmem_resp_valid = 1'b0;
    logic [XLEN-1:0]   dmem_resp_rdata = '0;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              misaligned_out;
    logic [XLEN-1:0]   fault_addr_out;
`endif

    mem_stage_access #(.XLEN(XLEN), .STRB_W(STRB_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .branch_in        (branch_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .funct3_in        (funct3_in),
        .branch_taken_out (branch_taken_out),
        .stall_out        (stall_out),
        .load_data_out    (load_data_out),
        .access_done_out  (access_done_out),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req_we      (dmem_req_we),
        .dmem_req_addr    (dmem_req_addr),
        .dmem_req_wdata   (dmem_req_wdata),
        .dmem_req_wstrb   (dmem_req_wstrb),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_resp_rdata  (dmem_resp_rdata)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned_out   (misaligned_out),
        .fault_addr_out   (fault_addr_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic        mis;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Monitor: compare presented requests against the head of the request
    // queue (every cycle, so fields must stay stable) and pop on handshake;
    // pop and compare a result on every completion pulse.
    always @(negedge clk) begin
        if (reset && dmem_req_valid) begin
            if (req_q.size() == 0) begin
                chk("req_unexpected", 64'd1, 64'd0);
            end else begin
                chk("req_we",    {63'd0, dmem_req_we}, {63'd0, req_q[0].we});
                chk("req_addr",  dmem_req_addr,  req_q[0].addr);
                chk("req_wdata", dmem_req_wdata, req_q[0].wdata);
                chk("req_wstrb", {56'd0, dmem_req_wstrb}, {56'd0, req_q[0].wstrb});
                if (dmem_req_ready) begin
                    void'(req_q.pop_front());
                end
            end
        end
        if (reset && access_done_out) begin
            if (res_q.size() == 0) begin
                chk("done_unexpected", 64'd1, 64'd0);
            end else begin
                res_t s;
                s = res_q.pop_front();
                chk("res_load", load_data_out, s.data);
`ifdef MEM_MISALIGN_TRAP_EN
                chk("res_misaligned", {63'd0, misaligned_out}, {63'd0, s.mis});
`endif
            end
        end
    end

    // One complete access with hand-computed expected lane fields and load
    // result; e_trap selects the no-bus misaligned path.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic [63:0] a, input logic [63:0] wd,
                              input logic [2:0] f3, input int rdy_dly,
                              input int resp_dly, input logic [63:0] rdata,
                              input logic [7:0] e_strb, input logic [63:0] e_wdata,
                              input logic [63:0] e_addr, input logic [63:0] e_load,
                              input logic e_trap);
        req_t r;
        res_t s;
        @(posedge clk); #1;
        mem_read_in  = rd;
        mem_write_in = wr;
        addr_in      = a;
        wdata_in     = wd;
        funct3_in    = f3;
        if (!e_trap) begin
            r.we    = wr;
            r.addr  = e_addr;
            r.wdata = e_wdata;
            r.wstrb = e_strb;
            req_q.push_back(r);
        end
        s.data = e_load;
        s.mis  = e_trap;
        res_q.push_back(s);
        @(negedge clk);
        chk({tag, "_stall_n"}, {63'd0, stall_out}, 64'd1);
        chk({tag, "_branch_stalled"}, {63'd0, branch_taken_out}, 64'd0);
        if (!e_trap) begin
            @(posedge clk); #1;
            for (int i = 0; i < rdy_dly; i++) begin
                @(negedge clk);
                chk({tag, "_stall_req"}, {63'd0, stall_out}, 64'd1);
                chk({tag, "_valid_hold"}, {63'd0, dmem_req_valid}, 64'd1);
                @(posedge clk); #1;
            end
            dmem_req_ready = 1'b1;
            @(negedge clk);
            chk({tag, "_stall_hs"}, {63'd0, stall_out}, 64'd1);
            chk({tag, "_valid_hs"}, {63'd0, dmem_req_valid}, 64'd1);
            @(posedge clk); #1;
            dmem_req_ready = 1'b0;
            for (int i = 0; i < resp_dly; i++) begin
                @(negedge clk);
                chk({tag, "_stall_wait"}, {63'd0, stall_out}, 64'd1);
                chk({tag, "_valid_wait"}, {63'd0, dmem_req_valid}, 64'd0);
                @(posedge clk); #1;
            end
            dmem_resp_valid = 1'b1;
            dmem_resp_rdata = rdata;
            @(negedge clk);
            chk({tag, "_stall_resp"}, {63'd0, stall_out}, 64'd1);
            @(posedge clk); #1;
            dmem_resp_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        mem_read_in  = 1'b0;
        mem_write_in = 1'b0;
        @(negedge clk);
        chk({tag, "_done"}, {63'd0, access_done_out}, 64'd1);
        chk({tag, "_stall_done"}, {63'd0, stall_out}, 64'd0);
        chk({tag, "_branch_done"}, {63'd0, branch_taken_out}, {63'd0, branch_in});
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, access_done_out}, 64'd0);
    endtask

    initial begin
        // Reset held 3 cycles with a pending load
        reset       = 1'b0;
        mem_read_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("rst_req_we",    {63'd0, dmem_req_we}, 64'd0);
        chk("rst_req_addr",  dmem_req_addr, 64'd0);
        chk("rst_req_wdata", dmem_req_wdata, 64'd0);
        chk("rst_req_wstrb", {56'd0, dmem_req_wstrb}, 64'd0);
        chk("rst_load",      load_data_out, 64'd0);
        chk("rst_done",      {63'd0, access_done_out}, 64'd0);
        @(posedge clk); #1;
        mem_read_in = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {63'd0, stall_out}, 64'd0);
        chk("post_rst_valid", {63'd0, dmem_req_valid}, 64'd0);

        // LB sign extension, minimum latency, branch gated by stall
        branch_in = 1'b1;
        run_access("lb", 1, 0, 64'h1003, 64'h0, 3'b000, 0, 0, 64'h00000000_80000000,
                   8'h08, 64'h0, 64'h1000, 64'hFFFFFFFF_FFFFFF80, 0);
        branch_in = 1'b0;
        // SH lane placement
        run_access("sh", 0, 1, 64'h2006, 64'hABCD, 3'b001, 0, 0, 64'h1111,
                   8'hC0, 64'hABCD0000_00000000, 64'h2000, 64'hFFFFFFFF_FFFFFF80, 0);
        // Backpressure: ready low 4 cycles, response 2 cycles later
        run_access("lwu_bp", 1, 0, 64'h4004, 64'h0, 3'b110, 4, 2, 64'h89ABCDEF_01234567,
                   8'hF0, 64'h0, 64'h4000, 64'h00000000_89ABCDEF, 0);
        run_access("lw", 1, 0, 64'h4004, 64'h0, 3'b010, 1, 1, 64'h89ABCDEF_01234567,
                   8'hF0, 64'h0, 64'h4000, 64'hFFFFFFFF_89ABCDEF, 0);
        run_access("lhu", 1, 0, 64'h6002, 64'h0, 3'b101, 0, 0, 64'h00000000_BEEF0000,
                   8'h0C, 64'h0, 64'h6000, 64'h00000000_0000BEEF, 0);
        run_access("lh", 1, 0, 64'h6002, 64'h0, 3'b001, 0, 1, 64'h00000000_BEEF0000,
                   8'h0C, 64'h0, 64'h6000, 64'hFFFFFFFF_FFFFBEEF, 0);
        run_access("lbu", 1, 0, 64'h6007, 64'h0, 3'b100, 0, 0, 64'hF1000000_00000000,
                   8'h80, 64'h0, 64'h6000, 64'h00000000_000000F1, 0);

        // Stray response and ready in IDLE must be ignored
        @(posedge clk); #1;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 64'hDEADDEAD_DEADDEAD;
        dmem_req_ready  = 1'b1;
        @(negedge clk);
        chk("stray_stall", {63'd0, stall_out}, 64'd0);
        @(posedge clk); #1;
        dmem_resp_valid = 1'b0;
        dmem_req_ready  = 1'b0;
        @(negedge clk);
        chk("stray_done",  {63'd0, access_done_out}, 64'd0);
        chk("stray_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("stray_load",  load_data_out, 64'h00000000_000000F1);

        // Read and write together: store wins, load data unchanged
        run_access("rw_sd", 1, 1, 64'h5000, 64'h01234567_89ABCDEF, 3'b011, 0, 0, 64'h5555,
                   8'hFF, 64'h01234567_89ABCDEF, 64'h5000, 64'h00000000_000000F1, 0);
        // funct3 111 behaves as D
        run_access("f3_111", 1, 0, 64'h7008, 64'h0, 3'b111, 0, 0, 64'hCAFEBABE_DEADBEEF,
                   8'hFF, 64'h0, 64'h7008, 64'hCAFEBABE_DEADBEEF, 0);

`ifdef MEM_MISALIGN_TRAP_EN
        run_access("mis_lw", 1, 0, 64'h3002, 64'h0, 3'b010, 0, 0, 64'h0,
                   8'h00, 64'h0, 64'h0, 64'hCAFEBABE_DEADBEEF, 1);
        chk("mis_lw_fault", fault_addr_out, 64'h3002);
        run_access("mis_sw", 0, 1, 64'h5006, 64'h11223344, 3'b010, 0, 0, 64'h0,
                   8'h00, 64'h0, 64'h0, 64'hCAFEBABE_DEADBEEF, 1);
        chk("mis_sw_fault", fault_addr_out, 64'h5006);
`else
        // Misaligned accesses are issued with truncated strobes
        run_access("mis_lw", 1, 0, 64'h3002, 64'h0, 3'b010, 0, 0, 64'h00001234_56789ABC,
                   8'h3C, 64'h0, 64'h3000, 64'h00000000_12345678, 0);
        run_access("mis_sw", 0, 1, 64'h5006, 64'h11223344, 3'b010, 0, 0, 64'h0,
                   8'hC0, 64'h33440000_00000000, 64'h5000, 64'h00000000_12345678, 0);
`endif

        // Reset in the middle of a request: no completion, valid drops
        @(posedge clk); #1;
        mem_read_in = 1'b1;
        addr_in     = 64'h8000;
        funct3_in   = 3'b011;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset       = 1'b1;
        mem_read_in = 1'b0;
        @(negedge clk);
        chk("midrst_valid", {63'd0, dmem_req_valid}, 64'd0);
        chk("midrst_done",  {63'd0, access_done_out}, 64'd0);
        chk("midrst_stall", {63'd0, stall_out}, 64'd0);
        chk("midrst_load",  load_data_out, 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_done2", {63'd0, access_done_out}, 64'd0);

        // Recovery after reset
        run_access("ld", 1, 0, 64'h7000, 64'h0, 3'b011, 2, 0, 64'h01020304_05060708,
                   8'hFF, 64'h0, 64'h7000, 64'h01020304_05060708, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("req_q_empty", 64'(req_q.size()), 64'd0);
        chk("res_q_empty", 64'(res_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
